// File: rtl/orv64_clk_gate_ctrl_if.sv
// Control/status bundle between a clock domain's activity sources and its gate-enable generator.
interface orv64_clk_gate_ctrl_if #(parameter int CNT_W = 16);
    logic             cfg_gate_en;
    logic             force_on;
    logic             busy;
    logic             wake_req;
    logic             clk_en;
    logic             wake_ack;
    logic             gated;
    logic [CNT_W-1:0] gate_evt_cnt;

    modport master (
        output cfg_gate_en, force_on, busy, wake_req,
        input  clk_en, wake_ack, gated, gate_evt_cnt
    );

    modport slave (
        input  cfg_gate_en, force_on, busy, wake_req,
        output clk_en, wake_ack, gated, gate_evt_cnt
    );
endinterface

// File: rtl/orv64_clk_gate_ctrl.sv
// Gate-enable generator for an orv64 clock-gating cell: idle-timeout gating, wake sequencing,
// four-phase wake handshake and a saturating gate-event counter. Runs on the ungated clock.
module orv64_clk_gate_ctrl #(
    parameter int IDLE_CYC = 16,
    parameter int WAKE_CYC = 2,
    parameter int CNT_W    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    orv64_clk_gate_ctrl_if.slave  cg
);
    localparam int IDLE_W = $clog2(IDLE_CYC + 1);
    localparam int WAKE_W = $clog2(WAKE_CYC + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYC - 1);
    localparam logic [WAKE_W-1:0] WAKE_LAST = WAKE_W'(WAKE_CYC - 1);

    typedef enum logic [1:0] {ST_RUN, ST_GATED, ST_WAKE} state_t;

    state_t            state, state_nxt;
    logic [IDLE_W-1:0] idle_cnt, idle_nxt;
    logic [WAKE_W-1:0] wake_cnt, wake_nxt;
    logic              act;
    logic              gate_evt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_comb begin
        state_nxt = state;
        idle_nxt  = '0;
        wake_nxt  = '0;
        gate_evt  = 1'b0;
        // An outstanding ack counts as activity so the domain cannot gate mid-handshake.
        act = cg.busy | cg.wake_req | cg.wake_ack | cg.force_on | ~cg.cfg_gate_en;
        unique case (state)
            ST_RUN: begin
                if (!act) begin
                    if (idle_cnt == IDLE_LAST) begin
                        state_nxt = ST_GATED;
                        gate_evt  = 1'b1;
                    end else begin
                        idle_nxt = idle_cnt + IDLE_W'(1);
                    end
                end
            end
            ST_GATED: begin
                if (act) state_nxt = ST_WAKE;
            end
            ST_WAKE: begin
                // Fixed-length settle window; activity here does not extend it.
                if (wake_cnt == WAKE_LAST) state_nxt = ST_RUN;
                else                       wake_nxt  = wake_cnt + WAKE_W'(1);
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_RUN;
            idle_cnt        <= '0;
            wake_cnt        <= '0;
            cg.clk_en       <= 1'b1;
            cg.wake_ack     <= 1'b0;
            cg.gated        <= 1'b0;
            cg.gate_evt_cnt <= '0;
        end else begin
            state       <= state_nxt;
            idle_cnt    <= idle_nxt;
            wake_cnt    <= wake_nxt;
            cg.clk_en   <= (state_nxt != ST_GATED);
            cg.gated    <= (state_nxt == ST_GATED);
            // Ack only once the clock is known stable, i.e. from RUN.
            cg.wake_ack <= (state == ST_RUN) && cg.wake_req;
            if (gate_evt) cg.gate_evt_cnt <= sat_inc(cg.gate_evt_cnt);
        end
    end
endmodule

// File: tb/tb_orv64_clk_gate_ctrl.sv
// Directed bench for orv64_clk_gate_ctrl: per-cycle comparison against a behavioural model
// plus literal expectations at the key points of each scenario.
module tb_orv64_clk_gate_ctrl;
    localparam int IDLE_CYC = 16;
    localparam int WAKE_CYC = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cfg_gate_en = 1'b1;
    logic force_on = 1'b0;
    logic busy = 1'b0;
    logic wake_req = 1'b0;
    logic cmp_en = 1'b0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    orv64_clk_gate_ctrl_if #(.CNT_W(16)) if1 ();
    orv64_clk_gate_ctrl_if #(.CNT_W(2))  if2 ();

    assign if1.cfg_gate_en = cfg_gate_en;
    assign if1.force_on    = force_on;
    assign if1.busy        = busy;
    assign if1.wake_req    = wake_req;
    assign if2.cfg_gate_en = cfg_gate_en;
    assign if2.force_on    = force_on;
    assign if2.busy        = busy;
    assign if2.wake_req    = wake_req;

    orv64_clk_gate_ctrl #(.IDLE_CYC(IDLE_CYC), .WAKE_CYC(WAKE_CYC), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .cg(if1)
    );
    orv64_clk_gate_ctrl #(.IDLE_CYC(IDLE_CYC), .WAKE_CYC(WAKE_CYC), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .cg(if2)
    );

    // Behavioural model: mode 0=running, 1=gated, 2=waking (counting down the settle window).
    int m_mode = 0;
    int m_idle_seen = 0;
    int m_wake_left = 0;
    int m_cnt = 0;
    int m_cnt2 = 0;
    bit m_clk_en = 1'b1;
    bit m_ack = 1'b0;
    bit m_gated = 1'b0;

    always @(posedge clk) begin
        bit a;
        bit new_ack;
        if (rst) begin
            m_mode = 0; m_idle_seen = 0; m_wake_left = 0;
            m_cnt = 0; m_cnt2 = 0; m_ack = 1'b0;
        end else begin
            a = busy | wake_req | m_ack | force_on | ~cfg_gate_en;
            new_ack = (m_mode == 0) && wake_req;
            if (m_mode == 0) begin
                if (a) m_idle_seen = 0;
                else begin
                    m_idle_seen++;
                    if (m_idle_seen == IDLE_CYC) begin
                        m_mode = 1;
                        m_idle_seen = 0;
                        if (m_cnt < 65535) m_cnt++;
                        if (m_cnt2 < 3) m_cnt2++;
                    end
                end
            end else if (m_mode == 1) begin
                if (a) begin m_mode = 2; m_wake_left = WAKE_CYC; end
            end else begin
                m_wake_left--;
                if (m_wake_left == 0) begin m_mode = 0; m_idle_seen = 0; end
            end
            m_ack = new_ack;
        end
        m_clk_en = (m_mode != 1);
        m_gated  = (m_mode == 1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_clk_en", 32'(if1.clk_en), 32'(m_clk_en));
            chk("model_wake_ack", 32'(if1.wake_ack), 32'(m_ack));
            chk("model_gated", 32'(if1.gated), 32'(m_gated));
            chk("model_cnt", 32'(if1.gate_evt_cnt), 32'(m_cnt));
            chk("model_cnt2", 32'(if2.gate_evt_cnt), 32'(m_cnt2));
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        step(2);
        cmp_en = 1'b1;
        chk("rst_clk_en", 32'(if1.clk_en), 32'd1);
        chk("rst_gated", 32'(if1.gated), 32'd0);
        chk("rst_ack", 32'(if1.wake_ack), 32'd0);
        chk("rst_cnt", 32'(if1.gate_evt_cnt), 32'd0);

        // 1: idle from release -> gated after 16 idle cycles
        rst = 1'b0;
        step(15);
        chk("t1_before_clk_en", 32'(if1.clk_en), 32'd1);
        step(1);
        chk("t1_clk_en", 32'(if1.clk_en), 32'd0);
        chk("t1_gated", 32'(if1.gated), 32'd1);
        chk("t1_cnt", 32'(if1.gate_evt_cnt), 32'd1);

        // 2: one-cycle busy pulse wakes, then a full idle window is needed again
        busy = 1'b1;
        step(1);
        busy = 1'b0;
        chk("t2_wake_clk_en", 32'(if1.clk_en), 32'd1);
        chk("t2_wake_gated", 32'(if1.gated), 32'd0);
        step(2 + 15);
        chk("t2_hold_clk_en", 32'(if1.clk_en), 32'd1);
        step(1);
        chk("t2_regate", 32'(if1.clk_en), 32'd0);
        chk("t2_cnt", 32'(if1.gate_evt_cnt), 32'd2);

        // 3: wake request from GATED -> ack at t+4, drops a cycle after req
        wake_req = 1'b1;
        step(3);
        chk("t3_ack_early", 32'(if1.wake_ack), 32'd0);
        step(1);
        chk("t3_ack", 32'(if1.wake_ack), 32'd1);
        wake_req = 1'b0;
        step(1);
        chk("t3_ack_drop", 32'(if1.wake_ack), 32'd0);

        // 4: activity on the threshold cycle wins
        busy = 1'b1; step(1);
        busy = 1'b0; step(15);
        busy = 1'b1; step(1);
        busy = 1'b0;
        chk("t4_clk_en", 32'(if1.clk_en), 32'd1);
        chk("t4_cnt", 32'(if1.gate_evt_cnt), 32'd2);
        step(15);
        chk("t4_hold", 32'(if1.clk_en), 32'd1);
        step(1);
        chk("t4_gate", 32'(if1.gated), 32'd1);
        chk("t4_cnt2", 32'(if2.gate_evt_cnt), 32'd3);

        // 5: cfg_gate_en drop while gated restores clock and blocks gating
        cfg_gate_en = 1'b0;
        step(1);
        chk("t5_clk_en", 32'(if1.clk_en), 32'd1);
        step(40);
        chk("t5_hold", 32'(if1.clk_en), 32'd1);
        cfg_gate_en = 1'b1;
        step(15);
        chk("t5_hold2", 32'(if1.clk_en), 32'd1);
        step(1);
        chk("t5_gate", 32'(if1.clk_en), 32'd0);
        chk("t5_cnt", 32'(if1.gate_evt_cnt), 32'd4);

        // force_on behaves like cfg=0; handshake still works under force
        force_on = 1'b1;
        step(1);
        chk("f_clk_en", 32'(if1.clk_en), 32'd1);
        wake_req = 1'b1;
        step(3);
        chk("f_ack", 32'(if1.wake_ack), 32'd1);
        wake_req = 1'b0;
        step(1);
        chk("f_ack_drop", 32'(if1.wake_ack), 32'd0);
        step(30);
        chk("f_hold", 32'(if1.clk_en), 32'd1);
        force_on = 1'b0;
        step(16);
        chk("f_gate", 32'(if1.gated), 32'd1);
        chk("f_cnt", 32'(if1.gate_evt_cnt), 32'd5);
        chk("f_cnt2_sat", 32'(if2.gate_evt_cnt), 32'd3);

        // 6: reset pulse while gated
        rst = 1'b1;
        step(1);
        chk("t6_clk_en", 32'(if1.clk_en), 32'd1);
        chk("t6_gated", 32'(if1.gated), 32'd0);
        chk("t6_cnt", 32'(if1.gate_evt_cnt), 32'd0);
        chk("t6_cnt2", 32'(if2.gate_evt_cnt), 32'd0);
        rst = 1'b0;
        step(3);

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
